// File: rtl/uart_rx.sv
// UART receiver: synchronised rx, mid-bit sampling, 8/9 data bits, 1/2 stop bits.
// Latency: valid pulses one clock after the last stop sample; no backpressure (data held until next frame).
package data_types_pkg;
  localparam int BR_DIV_W = 16;

  typedef struct packed {
    logic                en;
    logic                stop;
    logic                word;
    logic [BR_DIV_W-1:0] br_div;
  } ctrl_reg_t;
endpackage

module uart_rx
  import data_types_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  ctrl_reg_t  control,
  input  logic       rx,
  output logic [8:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       idle
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [BR_DIV_W-1:0] ONE = BR_DIV_W'(1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic                   rx_q;
  logic [1:0]             state;
  logic [BR_DIV_W-1:0]    cnt;
  logic [BR_DIV_W-1:0]    div_sh;
  logic                   word_sh;
  logic                   stop_sh;
  logic [3:0]             bit_idx;
  logic [8:0]             shreg;
  logic                   err;
  logic                   tick_half;
  logic                   tick_full;

  assign rx_s      = sync[SYNC_STAGES-1];
  assign idle      = (state == IDLE);
  assign tick_half = (cnt == (div_sh >> 1) - ONE);
  assign tick_full = (cnt == div_sh - ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync      <= '1;
      rx_q      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      div_sh    <= '0;
      word_sh   <= 1'b0;
      stop_sh   <= 1'b0;
      bit_idx   <= '0;
      shreg     <= '0;
      err       <= 1'b0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], rx};
      rx_q      <= rx_s;
      valid     <= 1'b0;
      frame_err <= 1'b0;

      if (state != IDLE && !control.en) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            // Only a genuine high-to-low edge starts a frame; a line stuck low does not.
            if (control.en && rx_q && !rx_s) begin
              state   <= START;
              cnt     <= '0;
              div_sh  <= control.br_div;
              word_sh <= control.word;
              stop_sh <= control.stop;
              bit_idx <= '0;
              err     <= 1'b0;
            end
          end
          START: begin
            if (tick_half) begin
              cnt   <= '0;
              state <= rx_s ? IDLE : DATA;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          DATA: begin
            if (tick_full) begin
              cnt   <= '0;
              shreg <= {rx_s, shreg[8:1]};
              if (bit_idx == (word_sh ? 4'd8 : 4'd7)) begin
                bit_idx <= '0;
                state   <= STOP;
              end else begin
                bit_idx <= bit_idx + 4'd1;
              end
            end else begin
              cnt <= cnt + ONE;
            end
          end
          STOP: begin
            if (tick_full) begin
              cnt <= '0;
              if (bit_idx == {3'b000, stop_sh}) begin
                state     <= IDLE;
                valid     <= 1'b1;
                frame_err <= err | ~rx_s;
                data      <= word_sh ? shreg : {1'b0, shreg[8:1]};
              end else begin
                err     <= err | ~rx_s;
                bit_idx <= bit_idx + 4'd1;
              end
            end else begin
              cnt <= cnt + ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that deserialises the asynchronous serial line produced by `uart_tx` into parallel words. It shares the `ctrl_reg_t` control word (from `data_types_pkg`) with the transmitter, so one register configures both directions. It sits between the pad-side `rx` line and the host/FIFO side, and emits one `valid` pulse per received frame.

## Interface
Parameters:
- `SYNC_STAGES`, 2: number of flops in the `rx` input synchroniser, minimum 2.

Ports:
- `clk`  in  1  system clock; the same clock as `uart_tx`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `control`  in  `ctrl_reg_t`  fields used: `br_div` (clocks per bit), `word` (0 = 8 data bits, 1 = 9 data bits), `stop` (0 = 1 stop bit, 1 = 2 stop bits), `en`.
- `rx`  in  1  serial line; idles high.
- `data`  out  9  last received word, LSB first on the line. Bit 8 is 0 in 8-bit mode.
- `valid`  out  1  one-cycle pulse when a frame completes.
- `frame_err`  out  1  asserted together with `valid` when any stop-bit sample reads low.
- `idle`  out  1  high when in IDLE.

## Operation
- Synchroniser: the `SYNC_STAGES` flops reset to 1. Everything below refers to the synchronised line `rx_s` and its previous value `rx_q`.
- States:
  - IDLE: wait for a start edge.
  - START: check the start bit.
  - DATA: shift in data bits.
  - STOP: check the stop bit(s).
- Counters:
  - Bit-timing counter `cnt`, the width of `br_div`.
  - Bit index `bit_idx`, 4 bits.
- IDLE -> START: on `en`=1 and a falling edge (`rx_q`=1, `rx_s`=0). A level low without a preceding high never starts a frame.
- On that transition, latch `br_div`, `word` and `stop` into shadow registers. Changes to `control` mid-frame do not affect the current frame.
- START:
  - Count `br_div>>1` cycles, then sample.
  - Sample = 0: go to DATA with `cnt` reloaded.
  - Sample = 1: glitch. Return to IDLE with no `valid`.
- DATA:
  - Sample every `br_div` cycles and shift right into `shreg[8:0]`.
  - Take 8 samples (`word`=0) or 9 samples (`word`=1), then go to STOP.
- STOP:
  - Sample 1 or 2 stop bits, each `br_div` cycles apart.
  - OR the inverted samples into an error flag.
  - After the last sample, return to IDLE.
- Completion: on the cycle after the last stop sample, `data` <= received word (zero-extended in 8-bit mode), `valid`=1 for one cycle, and `frame_err` = error flag.
- `data` holds its value until the next completed frame.
- `en` deasserted in any non-IDLE state: abort to IDLE on the next clock with no `valid`. `data` is unchanged.
- Constraint: `br_div` ≥ 4. Smaller values are unsupported and need not be checked.

## Timing
- Reset values: `data`=0, `valid`=0, `frame_err`=0, `idle`=1, state=IDLE, synchroniser=all 1s.
- `rst_n` low at any point, including mid-frame: all of the above immediately. No `valid` is produced for the interrupted frame.
- Input delay: a falling edge on `rx` reaches `rx_s` after `SYNC_STAGES` clocks.
- Sample times, with T0 = the cycle the edge is seen on `rx_s`:
  - Start sample at T0 + `br_div>>1`.
  - Data bit k at T0 + `br_div>>1` + (k+1)·`br_div`.
  - Stop bit j (j = 0..1) follows the last data bit at `br_div` spacing.
- `valid` is high exactly one cycle, one clock after the final stop sample.
- `idle` rises in that same cycle.
- Back-to-back frames: a new start edge is accepted on any cycle with `idle`=1, including the cycle `valid` is high. No dead time is required beyond the stop bit(s).
- `valid` and `frame_err` are never high outside that one-cycle pulse.
- `frame_err`=1 still delivers `data` and `valid`.

## Test plan
- Loopback from `uart_tx` to `uart_rx`, `br_div`=8, `word`=0, `stop`=0, send 0x8E then 0x81 -> exactly two `valid` pulses with `data`=0x08E then 0x081, and `frame_err`=0 both times.
- Same setup with `word`=1, send 0x1FE -> `data`=0x1FE, one `valid`.
- `stop`=1, bit-level driver sends 0x55 with the second stop bit low -> `data`=0x055, `valid`=1, `frame_err`=1. The next well-formed frame 0xAA -> `frame_err`=0.
- `rx` low for 2 clocks then high, `br_div`=8 -> no `valid`, `idle` back to 1 within 4+`SYNC_STAGES` clocks. A following valid frame 0x3C is received correctly.
- `rst_n` pulsed low during data bit 4 of 0xF0 -> outputs go to their reset values at once and no `valid` appears. A frame 0x0F sent after reset -> `data`=0x00F.
- `en` cleared mid-frame -> no `valid`, `data` holds its old value. Change `br_div` from 8 to 16 mid-frame -> the current frame is still decoded at 8.
